pio_spi_serializer: RTL and testbench

- Consumes the 8-bit parallel output of the Avalon PIO output-port stage and ships each new value to an external SPI slave (converter or expander) as an 8-bit SPI mode-0 frame.
- Detects value changes, or accepts a forced-send strobe.
- Generates cs_n/sclk/mosi with a programmable clock divider.
- Reports busy/done back to the system.

---
 rtl/pio_spi_pkg.sv | 30 +++
 rtl/spi_clk_tick.sv | 37 +++
 rtl/pio_spi_serializer.sv | 170 +++++++++++++++++
 tb/tb_pio_spi_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_spi_pkg.sv
// Shared types and constants for the PIO-to-SPI serializer.
// Optional readback path in the top is enabled by defining SPI_READBACK_EN.
package pio_spi_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CLK_DIV   = 4;
    localparam bit DEF_MSB_FIRST = 1'b1;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Clock divider for the SPI serializer: emits a one-clk tick every
// CLK_DIV cycles. i_restart holds the count at zero so that the first
// tick after release lands exactly CLK_DIV cycles later.
module spi_clk_tick
    import pio_spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int               CNT_W = clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_tick    = w_at_last;

    // Divide counter: wraps on the tick, cleared while restart is held.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pio_spi_serializer.sv
// Ships each new value from the PIO out_port to an SPI slave as one
// mode-0 frame (CPOL=0, data changes on sclk fall, sampled on rise).
// Define SPI_READBACK_EN to add the miso input and rx_data capture.
module pio_spi_serializer
    import pio_spi_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    output logic              busy,
    output logic              done
`ifdef SPI_READBACK_EN
    ,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data
`endif
);

    localparam int               BIT_W    = clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_last_sent;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_cs_n;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;

    logic w_tick;
    logic w_restart;
    logic w_start;
    logic w_sclk_rise;
    logic w_frame_end;

    // Bit that goes on the wire first for a given shift-register value.
    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    // Shift register after one bit has been sent.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Every non-IDLE transition happens on a tick, where the divider wraps
    // to zero by itself, so holding it in IDLE is enough to restart it on
    // every state entry.
    assign w_restart   = (r_state == IDLE);
    assign w_start     = (din != r_last_sent) || load;
    assign w_sclk_rise = (r_state == SHIFT) && w_tick && !r_sclk;
    assign w_frame_end = (r_state == HOLD) && w_tick;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Frame sequencer with registered SPI pins and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_last_sent <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: done is cleared here every cycle and only the HOLD exit
            // below overrides it, which makes it a single-cycle pulse.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shift     <= din;
                        r_last_sent <= din;
                        r_bit_cnt   <= '0;
                        r_busy      <= 1'b1;
                        r_cs_n      <= 1'b0;
                        r_mosi      <= first_bit(din);
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_sclk <= 1'b1;
                    end else if (w_tick) begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_shift   <= advance(r_shift);
                            r_mosi    <= first_bit(advance(r_shift));
                        end
                    end
                end
                HOLD: begin
                    if (w_frame_end) begin
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cs_n = r_cs_n;
    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign busy = r_busy;
    assign done = r_done;

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;

    // Sample miso on each sclk rise; publish the frame with the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            if (w_sclk_rise) begin
                r_rx_shift <= MSB_FIRST ? {r_rx_shift[DATA_W-2:0], miso}
                                        : {miso, r_rx_shift[DATA_W-1:1]};
            end
            if (w_frame_end) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign rx_data = r_rx_data;
`endif

endmodule

// File: tb/tb_pio_spi_serializer.sv
// Directed bench for pio_spi_serializer: one default instance (CLK_DIV=4,
// MSB first) and one CLK_DIV=1, LSB-first instance. Slave-side monitors
// rebuild each frame from the pins; with SPI_READBACK_EN, miso loops mosi.
module tb_pio_spi_serializer;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] din0    = 8'h00;
    logic [7:0] din1    = 8'h00;
    logic       load0   = 1'b0;
    logic       load1   = 1'b0;
    logic       cs0, sclk0, mosi0, busy0, done0;
    logic       cs1, sclk1, mosi1, busy1, done1;
`ifdef SPI_READBACK_EN
    logic [7:0] rx0, rx1;
`endif

    always #5 clk = ~clk;

    pio_spi_serializer #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .din(din0), .load(load0),
        .cs_n(cs0), .sclk(sclk0), .mosi(mosi0), .busy(busy0), .done(done0)
`ifdef SPI_READBACK_EN
        , .miso(mosi0), .rx_data(rx0)
`endif
    );

    pio_spi_serializer #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .din(din1), .load(load1),
        .cs_n(cs1), .sclk(sclk1), .mosi(mosi1), .busy(busy1), .done(done1)
`ifdef SPI_READBACK_EN
        , .miso(mosi1), .rx_data(rx1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks and land 2 time units after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Slave-side monitor, sampled on the falling clk edge.
    int         cyc = 0;
    logic       p_cs0 = 1'b1, p_sclk0 = 1'b0, p_busy0 = 1'b0;
    int         frames0 = 0, cur_low0 = 0, last_low0 = 0, cur_rise0 = 0, last_rise0 = 0;
    int         dones0 = 0, done_cyc0 = 0, busy_gap0 = 0, cur_busy0 = 0, last_busy0 = 0;
    logic [7:0] cur_rx0 = 8'h00, last_rx0 = 8'h00;

    logic       p_cs1 = 1'b1, p_sclk1 = 1'b0;
    int         frames1 = 0, cur_low1 = 0, last_low1 = 0, cur_rise1 = 0, last_rise1 = 0;
    int         dones1 = 0, rise_cyc1 = 0, rise_int1 = 0;
    logic [7:0] cur_rx1 = 8'h00, last_rx1 = 8'h00;

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        p_cs0   <= cs0;
        p_sclk0 <= sclk0;
        p_busy0 <= busy0;
        if (p_cs0 && !cs0) begin
            frames0   <= frames0 + 1;
            cur_low0  <= 1;
            cur_rise0 <= 0;
            cur_rx0   <= 8'h00;
        end else if (!cs0) begin
            cur_low0 <= cur_low0 + 1;
        end
        if (!p_cs0 && cs0) begin
            last_low0  <= cur_low0;
            last_rise0 <= cur_rise0;
            last_rx0   <= cur_rx0;
        end
        if (!cs0 && !p_sclk0 && sclk0) begin
            cur_rise0 <= cur_rise0 + 1;
            cur_rx0   <= {cur_rx0[6:0], mosi0};
        end
        if (done0) begin
            dones0    <= dones0 + 1;
            done_cyc0 <= cyc;
        end
        if (busy0) cur_busy0 <= cur_busy0 + 1;
        if (!p_busy0 && busy0) cur_busy0 <= 1;
        if (p_busy0 && !busy0) begin
            last_busy0 <= cur_busy0;
            busy_gap0  <= cyc - done_cyc0;
        end
    end

    always @(negedge clk) begin
        p_cs1   <= cs1;
        p_sclk1 <= sclk1;
        if (p_cs1 && !cs1) begin
            frames1   <= frames1 + 1;
            cur_low1  <= 1;
            cur_rise1 <= 0;
            cur_rx1   <= 8'h00;
        end else if (!cs1) begin
            cur_low1 <= cur_low1 + 1;
        end
        if (!p_cs1 && cs1) begin
            last_low1  <= cur_low1;
            last_rise1 <= cur_rise1;
            last_rx1   <= cur_rx1;
        end
        if (!cs1 && !p_sclk1 && sclk1) begin
            cur_rise1 <= cur_rise1 + 1;
            cur_rx1   <= {mosi1, cur_rx1[7:1]};
            rise_cyc1 <= cyc;
            if (cur_rise1 > 0) rise_int1 <= cyc - rise_cyc1;
        end
        if (done1) dones1 <= dones1 + 1;
    end

    initial begin
        int   n_rise;
        int   d_before;
        int   f_before;
        logic s_prev;

        // Power-on reset: outputs idle while reset_n is low.
        #3 reset_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(cs0), 1);
        check("rst_sclk", 32'(sclk0), 0);
        check("rst_mosi", 32'(mosi0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        tick(3);
        reset_n = 1'b1;

        // din stays 0 after reset: nothing is sent.
        tick(200);
        check("zero_frames", 32'(frames0), 0);
        check("zero_cs_n", 32'(cs0), 1);
        check("zero_busy", 32'(busy0), 0);

        // First frame 0xA5 with default timing.
        din0 = 8'hA5;
        tick(100);
        check("a5_frames", 32'(frames0), 1);
        check("a5_cs_low", 32'(last_low0), 72);
        check("a5_data", 32'(last_rx0), 'hA5);
        check("a5_rises", 32'(last_rise0), 8);
        check("a5_dones", 32'(dones0), 1);
        check("a5_busy_len", 32'(last_busy0), 76);
        check("a5_done_to_idle", 32'(busy_gap0), 4);
        check("a5_busy_end", 32'(busy0), 0);
`ifdef SPI_READBACK_EN
        check("a5_rx_data", 32'(rx0), 'hA5);
`endif

        // Forced resend of an unchanged value, then silence.
        load0 = 1'b1;
        tick(1);
        load0 = 1'b0;
        tick(100);
        check("load_frames", 32'(frames0), 2);
        check("load_data", 32'(last_rx0), 'hA5);
        check("load_cs_low", 32'(last_low0), 72);
        check("load_dones", 32'(dones0), 2);
        tick(200);
        check("steady_frames", 32'(frames0), 2);

        // Changes during a frame coalesce into one frame carrying the last.
        din0 = 8'h11;
        tick(10);
        din0 = 8'h22;
        tick(10);
        din0 = 8'h3C;
        tick(250);
        check("coalesce_frames", 32'(frames0), 4);
        check("coalesce_data", 32'(last_rx0), 'h3C);
        check("coalesce_dones", 32'(dones0), 4);

        // A load during a frame is dropped.
        load0 = 1'b1;
        tick(1);
        load0 = 1'b0;
        tick(20);
        load0 = 1'b1;
        tick(1);
        load0 = 1'b0;
        tick(200);
        check("drop_frames", 32'(frames0), 5);
        check("drop_data", 32'(last_rx0), 'h3C);

        // load and a din change together give a single frame.
        din0  = 8'h5A;
        load0 = 1'b1;
        tick(1);
        load0 = 1'b0;
        tick(150);
        check("both_frames", 32'(frames0), 6);
        check("both_data", 32'(last_rx0), 'h5A);
        check("both_dones", 32'(dones0), 6);

        // Abort a frame with reset at the 4th rising sclk.
        din0     = 8'h3C;
        n_rise   = 0;
        s_prev   = sclk0;
        f_before = frames0;
        for (int k = 0; k < 200 && n_rise < 4; k++) begin
            @(posedge clk);
            #1;
            if (sclk0 && !s_prev) n_rise++;
            s_prev = sclk0;
        end
        check("abort_reach_rise4", 32'(n_rise), 4);
        d_before = dones0;
        reset_n  = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs0), 1);
        check("abort_sclk", 32'(sclk0), 0);
        check("abort_mosi", 32'(mosi0), 0);
        check("abort_busy", 32'(busy0), 0);
        tick(3);
        check("abort_no_done", 32'(dones0), 32'(d_before));
        reset_n = 1'b1;
        tick(120);
        check("resend_frames", 32'(frames0), 32'(f_before + 2));
        check("resend_data", 32'(last_rx0), 'h3C);
        check("resend_cs_low", 32'(last_low0), 72);
        check("resend_dones", 32'(dones0), 32'(d_before + 1));
`ifdef SPI_READBACK_EN
        check("resend_rx_data", 32'(rx0), 'h3C);
`endif

        // Fast, LSB-first instance.
        check("div1_idle_frames", 32'(frames1), 0);
        din1 = 8'h01;
        tick(40);
        check("div1_frames", 32'(frames1), 1);
        check("div1_data", 32'(last_rx1), 'h01);
        check("div1_rises", 32'(last_rise1), 8);
        check("div1_sclk_period", 32'(rise_int1), 2);
        check("div1_cs_low", 32'(last_low1), 18);
        check("div1_dones", 32'(dones1), 1);
        check("div1_busy_end", 32'(busy1), 0);
`ifdef SPI_READBACK_EN
        check("div1_rx_data", 32'(rx1), 'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
